// File: rtl/issue_ctrl_if.sv
// issue_ctrl_if: instruction-queue head, writeback and issue handshake for issue_ctrl.
interface issue_ctrl_if #(parameter int STALL_CNT_W = 32);
    logic                   iq_valid0, iq_valid1;
    logic [4:0]             iq_rd0, iq_rd1, iq_rj0, iq_rj1, iq_rk0, iq_rk1;
    logic                   iq_wr0, iq_wr1;
    logic                   iq_is_ALU_0, iq_is_ALU_1;
    logic                   iq_is_priviledged_0, iq_is_priviledged_1;
    logic                   reg_allowin;
    logic                   wb_en0, wb_en1;
    logic [4:0]             wb_rd0, wb_rd1;
    logic                   priv_done;
    logic                   flush;
    logic                   issue0, issue1;
    logic                   drain_busy;
    logic [STALL_CNT_W-1:0] stall_cnt;

    modport master (
        output iq_valid0, iq_valid1, iq_rd0, iq_rd1, iq_rj0, iq_rj1, iq_rk0, iq_rk1,
               iq_wr0, iq_wr1, iq_is_ALU_0, iq_is_ALU_1, iq_is_priviledged_0, iq_is_priviledged_1,
               reg_allowin, wb_en0, wb_en1, wb_rd0, wb_rd1, priv_done, flush,
        input  issue0, issue1, drain_busy, stall_cnt
    );

    modport slave (
        input  iq_valid0, iq_valid1, iq_rd0, iq_rd1, iq_rj0, iq_rj1, iq_rk0, iq_rk1,
               iq_wr0, iq_wr1, iq_is_ALU_0, iq_is_ALU_1, iq_is_priviledged_0, iq_is_priviledged_1,
               reg_allowin, wb_en0, wb_en1, wb_rd0, wb_rd1, priv_done, flush,
        output issue0, issue1, drain_busy, stall_cnt
    );
endinterface

// File: rtl/issue_ctrl.sv
// issue_ctrl: in-order dual-slot issue with register scoreboard and privileged drain.
// Dual issue of slot 1 is enabled by defining ISSUE_CTRL_DUAL_ISSUE_EN.
module issue_ctrl #(
    parameter int STALL_CNT_W = 32
) (
    input logic        aclk,
    input logic        areset,
    issue_ctrl_if.slave bus
);
    typedef enum logic {NORMAL, DRAIN} state_t;

    state_t                 state;
    logic [31:0]            busy, set_v, clr_v;
    logic [STALL_CNT_W-1:0] cnt;
    logic                   issue0, issue1, w0, w1;

    always_comb begin
        w0 = bus.iq_wr0 && bus.iq_rd0 != 5'd0;
        issue0 = !areset && state == NORMAL && !bus.flush && bus.reg_allowin && bus.iq_valid0 &&
                 !busy[bus.iq_rj0] && !busy[bus.iq_rk0] &&
                 (!bus.iq_is_priviledged_0 || busy == 32'd0);
    end

`ifdef ISSUE_CTRL_DUAL_ISSUE_EN
    always_comb begin
        w1 = bus.iq_wr1 && bus.iq_rd1 != 5'd0;
        issue1 = issue0 && bus.iq_valid1 && !bus.iq_is_priviledged_0 && !bus.iq_is_priviledged_1 &&
                 !busy[bus.iq_rj1] && !busy[bus.iq_rk1] &&
                 !(w0 && (bus.iq_rj1 == bus.iq_rd0 || bus.iq_rk1 == bus.iq_rd0)) &&
                 (bus.iq_is_ALU_0 || bus.iq_is_ALU_1);
    end
`else
    assign w1     = 1'b0;
    assign issue1 = 1'b0;
`endif

    always_comb begin
        set_v = ({31'd0, issue0 && w0} << bus.iq_rd0) | ({31'd0, issue1 && w1} << bus.iq_rd1);
        clr_v = ({31'd0, bus.wb_en0} << bus.wb_rd0) | ({31'd0, bus.wb_en1} << bus.wb_rd1);
    end

    // Set is applied after clear so a same-edge reissue keeps the register busy.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state <= NORMAL;
            busy  <= '0;
            cnt   <= '0;
        end else begin
            if (bus.iq_valid0 && !issue0) cnt <= cnt + 1'b1;
            if (bus.flush) begin
                busy  <= '0;
                state <= NORMAL;
            end else begin
                busy  <= ((busy & ~clr_v) | set_v) & ~32'd1;
                state <= state == DRAIN ? (bus.priv_done ? NORMAL : DRAIN)
                                        : (issue0 && bus.iq_is_priviledged_0 ? DRAIN : NORMAL);
            end
        end
    end

    assign bus.issue0     = issue0;
    assign bus.issue1     = issue1;
    assign bus.drain_busy = state == DRAIN;
    assign bus.stall_cnt  = cnt;
endmodule

// File: tb/tb_issue_ctrl.sv
// tb_issue_ctrl: directed scenarios plus randomized traffic against a behavioural scoreboard model.
module tb_issue_ctrl;
    logic aclk, areset;
    int   nchk = 0, nerr = 0;

    bit [31:0] m_busy;
    bit        m_drain;
    int        m_cnt;
`ifdef ISSUE_CTRL_DUAL_ISSUE_EN
    localparam bit DUAL = 1'b1;
`else
    localparam bit DUAL = 1'b0;
`endif

    issue_ctrl_if #(.STALL_CNT_W(4)) bus();
    issue_ctrl #(.STALL_CNT_W(4)) dut (.aclk(aclk), .areset(areset), .bus(bus));

    initial begin
        aclk = 0;
        forever #5 aclk = ~aclk;
    end

    function automatic bit exp_i0();
        if (areset || m_drain || bus.flush || !bus.reg_allowin || !bus.iq_valid0) return 0;
        if (m_busy[bus.iq_rj0] || m_busy[bus.iq_rk0]) return 0;
        if (bus.iq_is_priviledged_0 && m_busy != 0) return 0;
        return 1;
    endfunction

    function automatic bit exp_i1();
        if (!DUAL || !exp_i0() || !bus.iq_valid1) return 0;
        if (bus.iq_is_priviledged_0 || bus.iq_is_priviledged_1) return 0;
        if (m_busy[bus.iq_rj1] || m_busy[bus.iq_rk1]) return 0;
        if (bus.iq_wr0 && bus.iq_rd0 != 0 && (bus.iq_rj1 == bus.iq_rd0 || bus.iq_rk1 == bus.iq_rd0)) return 0;
        if (!bus.iq_is_ALU_0 && !bus.iq_is_ALU_1) return 0;
        return 1;
    endfunction

    task automatic tick();
        bit e0, e1;
        e0 = exp_i0();
        e1 = exp_i1();
        if (areset) begin
            m_busy = 0; m_drain = 0; m_cnt = 0;
        end else begin
            if (bus.iq_valid0 && !e0) m_cnt = (m_cnt + 1) % 16;
            if (bus.flush) begin
                m_busy = 0; m_drain = 0;
            end else begin
                if (bus.wb_en0) m_busy[bus.wb_rd0] = 0;
                if (bus.wb_en1) m_busy[bus.wb_rd1] = 0;
                if (e0 && bus.iq_wr0 && bus.iq_rd0 != 0) m_busy[bus.iq_rd0] = 1;
                if (e1 && bus.iq_wr1 && bus.iq_rd1 != 0) m_busy[bus.iq_rd1] = 1;
                if (m_drain) begin
                    if (bus.priv_done) m_drain = 0;
                end else if (e0 && bus.iq_is_priviledged_0) m_drain = 1;
            end
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic idle();
        bus.iq_valid0 = 0; bus.iq_valid1 = 0;
        bus.iq_rd0 = 0; bus.iq_rj0 = 0; bus.iq_rk0 = 0; bus.iq_rd1 = 0; bus.iq_rj1 = 0; bus.iq_rk1 = 0;
        bus.iq_wr0 = 0; bus.iq_wr1 = 0; bus.iq_is_ALU_0 = 1; bus.iq_is_ALU_1 = 1;
        bus.iq_is_priviledged_0 = 0; bus.iq_is_priviledged_1 = 0;
        bus.reg_allowin = 1; bus.wb_en0 = 0; bus.wb_en1 = 0; bus.wb_rd0 = 0; bus.wb_rd1 = 0;
        bus.priv_done = 0; bus.flush = 0;
    endtask

    task automatic set0(input logic [4:0] rd, rj, rk, input bit wr, alu, priv);
        bus.iq_valid0 = 1; bus.iq_rd0 = rd; bus.iq_rj0 = rj; bus.iq_rk0 = rk;
        bus.iq_wr0 = wr; bus.iq_is_ALU_0 = alu; bus.iq_is_priviledged_0 = priv;
    endtask

    task automatic set1(input logic [4:0] rd, rj, rk, input bit wr, alu, priv);
        bus.iq_valid1 = 1; bus.iq_rd1 = rd; bus.iq_rj1 = rj; bus.iq_rk1 = rk;
        bus.iq_wr1 = wr; bus.iq_is_ALU_1 = alu; bus.iq_is_priviledged_1 = priv;
    endtask

    task automatic test_reset();
        idle();
        areset = 1;
        set0(5'd1, 5'd2, 5'd3, 1, 1, 0);
        #1;
        nchk++; if (bus.issue0 !== 1'b0) begin nerr++; $display("FAIL reset_issue0 got=%0b exp=0", bus.issue0); end
        nchk++; if (bus.issue1 !== 1'b0) begin nerr++; $display("FAIL reset_issue1 got=%0b exp=0", bus.issue1); end
        tick();
        tick();
        nchk++; if (bus.stall_cnt !== 4'd0) begin nerr++; $display("FAIL reset_cnt got=%0d exp=0", bus.stall_cnt); end
        nchk++; if (bus.drain_busy !== 1'b0) begin nerr++; $display("FAIL reset_drain got=%0b exp=0", bus.drain_busy); end
        areset = 0;
        idle();
        #1;
    endtask

    task automatic test_basic();
        set0(5'd5, 5'd3, 5'd4, 1, 1, 0);
        #1;
        nchk++; if (bus.issue0 !== 1'b1) begin nerr++; $display("FAIL basic_issue got=%0b exp=1", bus.issue0); end
        tick();
        set0(5'd6, 5'd5, 5'd0, 1, 1, 0);
        #1;
        nchk++; if (bus.issue0 !== 1'b0) begin nerr++; $display("FAIL raw_stall got=%0b exp=0", bus.issue0); end
        tick();
        nchk++; if (bus.stall_cnt !== 4'd1) begin nerr++; $display("FAIL stall_cnt_inc got=%0d exp=1", bus.stall_cnt); end
        bus.wb_en0 = 1; bus.wb_rd0 = 5'd5;
        tick();
        bus.wb_en0 = 0;
        #1;
        nchk++; if (bus.issue0 !== 1'b1) begin nerr++; $display("FAIL raw_release got=%0b exp=1", bus.issue0); end
        idle();
        tick();
    endtask

    task automatic test_dual();
        set0(5'd6, 5'd1, 5'd2, 1, 1, 0);
        set1(5'd8, 5'd6, 5'd3, 1, 1, 0);
        #1;
        nchk++; if (bus.issue0 !== 1'b1) begin nerr++; $display("FAIL dual_dep_i0 got=%0b exp=1", bus.issue0); end
        nchk++; if (bus.issue1 !== 1'b0) begin nerr++; $display("FAIL dual_dep_i1 got=%0b exp=0", bus.issue1); end
        set1(5'd8, 5'd10, 5'd11, 1, 1, 0);
        #1;
        nchk++; if (bus.issue1 !== DUAL) begin nerr++; $display("FAIL dual_indep_i1 got=%0b exp=%0b", bus.issue1, DUAL); end
        bus.iq_is_ALU_0 = 0; bus.iq_is_ALU_1 = 0;
        #1;
        nchk++; if (bus.issue1 !== 1'b0) begin nerr++; $display("FAIL dual_nonalu_i1 got=%0b exp=0", bus.issue1); end
        set0(5'd12, 5'd1, 5'd2, 1, 1, 0);
        set1(5'd12, 5'd13, 5'd14, 1, 1, 0);
        #1;
        nchk++; if (bus.issue1 !== DUAL) begin nerr++; $display("FAIL dual_same_rd got=%0b exp=%0b", bus.issue1, DUAL); end
        tick();
        idle();
        set0(5'd0, 5'd12, 5'd0, 0, 1, 0);
        #1;
        nchk++; if (bus.issue0 !== 1'b0) begin nerr++; $display("FAIL same_rd_busy got=%0b exp=0", bus.issue0); end
        idle();
        bus.wb_en0 = 1; bus.wb_rd0 = 5'd12;
        tick();
        idle();
    endtask

    task automatic test_wb();
        set0(5'd7, 5'd1, 5'd2, 1, 1, 0);
        tick();
        bus.wb_en0 = 1; bus.wb_rd0 = 5'd7;
        #1;
        nchk++; if (bus.issue0 !== 1'b1) begin nerr++; $display("FAIL wb_reissue got=%0b exp=1", bus.issue0); end
        tick();
        idle();
        set0(5'd0, 5'd7, 5'd0, 0, 1, 0);
        #1;
        nchk++; if (bus.issue0 !== 1'b0) begin nerr++; $display("FAIL set_wins got=%0b exp=0", bus.issue0); end
        idle();
        bus.wb_en0 = 1; bus.wb_rd0 = 5'd7;
        tick();
        idle();
        set0(5'd0, 5'd7, 5'd0, 0, 1, 0);
        #1;
        nchk++; if (bus.issue0 !== 1'b1) begin nerr++; $display("FAIL wb_clear got=%0b exp=1", bus.issue0); end
        set0(5'd7, 5'd1, 5'd2, 1, 1, 0);
        tick();
        idle();
        bus.wb_en0 = 1; bus.wb_rd0 = 5'd0;
        tick();
        idle();
        set0(5'd0, 5'd0, 5'd7, 0, 1, 0);
        #1;
        nchk++; if (bus.issue0 !== 1'b0) begin nerr++; $display("FAIL wb_r0_nochange got=%0b exp=0", bus.issue0); end
        idle();
        bus.wb_en1 = 1; bus.wb_rd1 = 5'd7;
        tick();
        idle();
        set0(5'd0, 5'd0, 5'd7, 0, 1, 0);
        #1;
        nchk++; if (bus.issue0 !== 1'b1) begin nerr++; $display("FAIL wb1_clear got=%0b exp=1", bus.issue0); end
        idle();
        #1;
    endtask

    task automatic test_priv();
        set0(5'd2, 5'd1, 5'd1, 1, 1, 0);
        tick();
        idle();
        set0(5'd0, 5'd3, 5'd4, 0, 0, 1);
        #1;
        nchk++; if (bus.issue0 !== 1'b0) begin nerr++; $display("FAIL priv_wait got=%0b exp=0", bus.issue0); end
        bus.wb_en0 = 1; bus.wb_rd0 = 5'd2;
        tick();
        bus.wb_en0 = 0;
        #1;
        nchk++; if (bus.issue0 !== 1'b1) begin nerr++; $display("FAIL priv_issue got=%0b exp=1", bus.issue0); end
        tick();
        set0(5'd0, 5'd3, 5'd4, 0, 1, 0);
        #1;
        nchk++; if (bus.drain_busy !== 1'b1) begin nerr++; $display("FAIL drain_enter got=%0b exp=1", bus.drain_busy); end
        nchk++; if (bus.issue0 !== 1'b0) begin nerr++; $display("FAIL drain_block got=%0b exp=0", bus.issue0); end
        tick();
        tick();
        bus.priv_done = 1;
        #1;
        nchk++; if (bus.issue0 !== 1'b0) begin nerr++; $display("FAIL drain_done_cycle got=%0b exp=0", bus.issue0); end
        tick();
        bus.priv_done = 0;
        #1;
        nchk++; if (bus.drain_busy !== 1'b0) begin nerr++; $display("FAIL drain_exit got=%0b exp=0", bus.drain_busy); end
        nchk++; if (bus.issue0 !== 1'b1) begin nerr++; $display("FAIL post_drain_issue got=%0b exp=1", bus.issue0); end
        nchk++; if (bus.stall_cnt !== 4'(m_cnt)) begin nerr++; $display("FAIL drain_stall_cnt got=%0d exp=%0d", bus.stall_cnt, m_cnt); end
        idle();
        tick();
    endtask

    task automatic test_flush();
        set0(5'd9, 5'd1, 5'd2, 1, 0, 1);
        tick();
        set0(5'd0, 5'd9, 5'd0, 0, 1, 0);
        bus.flush = 1; bus.priv_done = 1;
        #1;
        nchk++; if (bus.issue0 !== 1'b0) begin nerr++; $display("FAIL flush_block got=%0b exp=0", bus.issue0); end
        tick();
        bus.flush = 0; bus.priv_done = 0;
        #1;
        nchk++; if (bus.drain_busy !== 1'b0) begin nerr++; $display("FAIL flush_normal got=%0b exp=0", bus.drain_busy); end
        nchk++; if (bus.issue0 !== 1'b1) begin nerr++; $display("FAIL flush_sb_clear got=%0b exp=1", bus.issue0); end
        nchk++; if (bus.stall_cnt !== 4'(m_cnt) || m_cnt == 0) begin nerr++; $display("FAIL flush_keeps_cnt got=%0d exp=%0d", bus.stall_cnt, m_cnt); end
        set0(5'd9, 5'd1, 5'd2, 1, 0, 1);
        tick();
        idle();
        #1;
        nchk++; if (bus.drain_busy !== 1'b1) begin nerr++; $display("FAIL drain_reenter got=%0b exp=1", bus.drain_busy); end
        areset = 1;
        tick();
        areset = 0;
        #1;
        nchk++; if (bus.stall_cnt !== 4'd0) begin nerr++; $display("FAIL rst_drain_cnt got=%0d exp=0", bus.stall_cnt); end
        nchk++; if (bus.drain_busy !== 1'b0) begin nerr++; $display("FAIL rst_drain_state got=%0b exp=0", bus.drain_busy); end
        bus.priv_done = 1; bus.wb_en0 = 1; bus.wb_rd0 = 5'd9;
        tick();
        idle();
        set0(5'd0, 5'd9, 5'd9, 0, 1, 0);
        #1;
        nchk++; if (bus.issue0 !== 1'b1) begin nerr++; $display("FAIL post_reset_clear got=%0b exp=1", bus.issue0); end
        idle();
        #1;
    endtask

    task automatic test_wrap();
        areset = 1;
        tick();
        areset = 0;
        bus.reg_allowin = 0;
        set0(5'd1, 5'd2, 5'd3, 1, 1, 0);
        repeat (15) tick();
        nchk++; if (bus.stall_cnt !== 4'hf) begin nerr++; $display("FAIL cnt_allones got=%0d exp=15", bus.stall_cnt); end
        tick();
        nchk++; if (bus.stall_cnt !== 4'h0) begin nerr++; $display("FAIL cnt_wrap got=%0d exp=0", bus.stall_cnt); end
        idle();
        #1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            bus.iq_valid0 = $urandom_range(0, 9) < 8; bus.iq_valid1 = $urandom_range(0, 9) < 8;
            bus.iq_rd0 = 5'($urandom_range(0, 7)); bus.iq_rj0 = 5'($urandom_range(0, 7)); bus.iq_rk0 = 5'($urandom_range(0, 7));
            bus.iq_rd1 = 5'($urandom_range(0, 7)); bus.iq_rj1 = 5'($urandom_range(0, 7)); bus.iq_rk1 = 5'($urandom_range(0, 7));
            bus.iq_wr0 = $urandom_range(0, 9) < 7; bus.iq_wr1 = $urandom_range(0, 9) < 7;
            bus.iq_is_ALU_0 = $urandom_range(0, 9) < 6; bus.iq_is_ALU_1 = $urandom_range(0, 9) < 6;
            bus.iq_is_priviledged_0 = $urandom_range(0, 19) == 0; bus.iq_is_priviledged_1 = $urandom_range(0, 19) == 0;
            bus.reg_allowin = $urandom_range(0, 9) < 8;
            bus.wb_en0 = $urandom_range(0, 9) < 4; bus.wb_en1 = $urandom_range(0, 9) < 3;
            bus.wb_rd0 = 5'($urandom_range(0, 7)); bus.wb_rd1 = 5'($urandom_range(0, 7));
            bus.priv_done = $urandom_range(0, 9) < 2; bus.flush = $urandom_range(0, 39) == 0;
            areset = $urandom_range(0, 199) == 0;
            #1;
            nchk++; if (bus.issue0 !== exp_i0()) begin nerr++; $display("FAIL rnd_issue0 cyc=%0d got=%0b exp=%0b", i, bus.issue0, exp_i0()); end
            nchk++; if (bus.issue1 !== exp_i1()) begin nerr++; $display("FAIL rnd_issue1 cyc=%0d got=%0b exp=%0b", i, bus.issue1, exp_i1()); end
            nchk++; if (bus.drain_busy !== m_drain) begin nerr++; $display("FAIL rnd_drain cyc=%0d got=%0b exp=%0b", i, bus.drain_busy, m_drain); end
            nchk++; if (bus.stall_cnt !== 4'(m_cnt)) begin nerr++; $display("FAIL rnd_cnt cyc=%0d got=%0d exp=%0d", i, bus.stall_cnt, m_cnt); end
            tick();
        end
        areset = 0;
        idle();
    endtask

    initial begin
        areset = 1;
        m_busy = 0; m_drain = 0; m_cnt = 0;
        idle();
        @(posedge aclk);
        #1;
        test_reset();
        test_basic();
        test_dual();
        test_wb();
        test_priv();
        test_flush();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
